// File: rtl/isp_yuv444to422_if.sv
// rtl/isp_yuv444to422_if.sv - pixel bus between the gamma stage, the 444->422 converter and the formatter
// slave: converter side (takes YUV444, drives YUV422); master: upstream/downstream side.
interface isp_yuv444to422_if #(
  parameter int BITS = 8
);
  logic            in_href;
  logic            in_vsync;
  logic [BITS-1:0] in_y;
  logic [BITS-1:0] in_u;
  logic [BITS-1:0] in_v;
  logic            out_href;
  logic            out_vsync;
  logic [BITS-1:0] out_y;
  logic [BITS-1:0] out_c;
  logic            out_c_sel;

  modport slave (
    input  in_href, in_vsync, in_y, in_u, in_v,
    output out_href, out_vsync, out_y, out_c, out_c_sel
  );

  modport master (
    output in_href, in_vsync, in_y, in_u, in_v,
    input  out_href, out_vsync, out_y, out_c, out_c_sel
  );
endinterface

// File: rtl/isp_yuv444to422.sv
// rtl/isp_yuv444to422.sv - YUV444 to YUV422 chroma subsampler, two-stage pipeline
// Each even/odd pixel pair shares one U and one V (pair average or decimation).
module isp_yuv444to422 #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter bit AVG_EN = 1'b1
) (
  input  logic                     pclk,
  input  logic                     rst,
  isp_yuv444to422_if.slave         bus
);

  // Frame geometry is informational only and has no effect on the datapath.
  if (WIDTH < 2 || HEIGHT < 1) begin : g_geometry_degenerate
  end

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } phase_e;

  function automatic logic [BITS-1:0] avg2(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    logic [BITS:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, 1'b1};
    return sum[BITS:1];
  endfunction

  phase_e phase_q, phase_d;
  logic   pix_odd;
  logic   pair_close;

  logic            s1_href_q,  s1_href_d;
  logic            s1_vsync_q, s1_vsync_d;
  logic            s1_odd_q,   s1_odd_d;
  logic [BITS-1:0] s1_y_q,     s1_y_d;
  logic [BITS-1:0] s1_u_q,     s1_u_d;
  logic [BITS-1:0] s1_v_q,     s1_v_d;

  logic [BITS-1:0] v_hold_q,   v_hold_d;
  logic [BITS-1:0] u_pair;
  logic [BITS-1:0] v_pair;

  logic            out_href_q,  out_href_d;
  logic            out_vsync_q, out_vsync_d;
  logic [BITS-1:0] out_y_q,     out_y_d;
  logic [BITS-1:0] out_c_q,     out_c_d;
  logic            out_c_sel_q, out_c_sel_d;

  // Phase FSM: state register
  always_ff @(posedge pclk) begin
    if (rst) begin
      phase_q <= PH_EVEN;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase FSM: next state; any cycle without href restarts the line at EVEN
  always_comb begin
    phase_d = PH_EVEN;
    if (bus.in_href) begin
      phase_d = (phase_q == PH_EVEN) ? PH_ODD : PH_EVEN;
    end
  end

  // Phase FSM: outputs. pair_close marks the odd pixel completing the pair held in stage1.
  always_comb begin
    pix_odd    = 1'b0;
    pair_close = 1'b0;
    if (bus.in_href && (phase_q == PH_ODD)) begin
      pix_odd    = 1'b1;
      pair_close = s1_href_q && !s1_odd_q;
    end
  end

  always_comb begin
    s1_href_d  = bus.in_href;
    s1_vsync_d = bus.in_vsync;
    s1_odd_d   = pix_odd;
    s1_y_d     = bus.in_y;
    s1_u_d     = bus.in_u;
    s1_v_d     = bus.in_v;
  end

  // Chroma for the pair is formed from the even pixel in stage1 and the odd pixel at the input.
  always_comb begin
    u_pair = AVG_EN ? avg2(s1_u_q, bus.in_u) : s1_u_q;
    v_pair = AVG_EN ? avg2(s1_v_q, bus.in_v) : bus.in_v;
    v_hold_d = v_hold_q;
    if (pair_close) begin
      v_hold_d = v_pair;
    end
  end

  always_comb begin
    out_href_d  = s1_href_q;
    out_vsync_d = s1_vsync_q;
    out_y_d     = '0;
    out_c_d     = '0;
    out_c_sel_d = 1'b0;
    if (s1_href_q) begin
      out_y_d = s1_y_q;
      if (s1_odd_q) begin
        out_c_d     = v_hold_q;
        out_c_sel_d = 1'b1;
      end else begin
        // An even pixel without a partner carries its own U; its V is dropped.
        out_c_d     = pair_close ? u_pair : s1_u_q;
        out_c_sel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_href_q   <= 1'b0;
      s1_vsync_q  <= 1'b0;
      s1_odd_q    <= 1'b0;
      s1_y_q      <= '0;
      s1_u_q      <= '0;
      s1_v_q      <= '0;
      v_hold_q    <= '0;
      out_href_q  <= 1'b0;
      out_vsync_q <= 1'b0;
      out_y_q     <= '0;
      out_c_q     <= '0;
      out_c_sel_q <= 1'b0;
    end else begin
      s1_href_q   <= s1_href_d;
      s1_vsync_q  <= s1_vsync_d;
      s1_odd_q    <= s1_odd_d;
      s1_y_q      <= s1_y_d;
      s1_u_q      <= s1_u_d;
      s1_v_q      <= s1_v_d;
      v_hold_q    <= v_hold_d;
      out_href_q  <= out_href_d;
      out_vsync_q <= out_vsync_d;
      out_y_q     <= out_y_d;
      out_c_q     <= out_c_d;
      out_c_sel_q <= out_c_sel_d;
    end
  end

  assign bus.out_href  = out_href_q;
  assign bus.out_vsync = out_vsync_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_c     = out_c_q;
  assign bus.out_c_sel = out_c_sel_q;

endmodule

// File: tb/tb_isp_yuv444to422.sv
// tb/tb_isp_yuv444to422.sv - directed scoreboard bench for isp_yuv444to422 (averaging and decimating)
// Both variants see identical input; each has its own expected-pixel queue.
module tb_isp_yuv444to422;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] c;
    logic       sel;
  } pix_t;

  logic pclk = 1'b0;
  logic rst;
  always #5 pclk = ~pclk;

  isp_yuv444to422_if #(.BITS(8)) if1 ();
  isp_yuv444to422_if #(.BITS(8)) if0 ();

  isp_yuv444to422 #(.BITS(8), .WIDTH(1280), .HEIGHT(960), .AVG_EN(1'b1)) dut_avg (
    .pclk (pclk),
    .rst  (rst),
    .bus  (if1)
  );

  isp_yuv444to422 #(.BITS(8), .WIDTH(1280), .HEIGHT(960), .AVG_EN(1'b0)) dut_dec (
    .pclk (pclk),
    .rst  (rst),
    .bus  (if0)
  );

  int   errors = 0;
  int   checks = 0;
  pix_t q1[$];
  pix_t q0[$];
  logic [7:0] ly[16];
  logic [7:0] lu[16];
  logic [7:0] lv[16];
  // href/vsync expected for the output, driven one (a) and two (b) cycles ago
  logic exp_a_h = 1'b0, exp_a_v = 1'b0, exp_b_h = 1'b0, exp_b_v = 1'b0;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

  task automatic chk_dut(input int id, input logic oh, input logic ov,
                         input logic [7:0] oy, input logic [7:0] oc, input logic os);
    pix_t e;
    int   sz;
    expect_eq($sformatf("d%0d_href", id), {31'd0, oh}, {31'd0, exp_b_h});
    expect_eq($sformatf("d%0d_vsync", id), {31'd0, ov}, {31'd0, exp_b_v});
    if (oh === 1'b1) begin
      sz = (id == 1) ? q1.size() : q0.size();
      checks++;
      assert (sz > 0) else begin
        errors++;
        $error("FAIL d%0d_extra_pixel observed=y%0d expected=no pixel", id, oy);
      end
      if (sz > 0) begin
        e = (id == 1) ? q1.pop_front() : q0.pop_front();
        expect_eq($sformatf("d%0d_y", id), {24'd0, oy}, {24'd0, e.y});
        expect_eq($sformatf("d%0d_c(y=%0d)", id, e.y), {24'd0, oc}, {24'd0, e.c});
        expect_eq($sformatf("d%0d_sel(y=%0d)", id, e.y), {31'd0, os}, {31'd0, e.sel});
      end
    end else begin
      expect_eq($sformatf("d%0d_gate_y", id), {24'd0, oy}, 32'd0);
      expect_eq($sformatf("d%0d_gate_c", id), {24'd0, oc}, 32'd0);
      expect_eq($sformatf("d%0d_gate_sel", id), {31'd0, os}, 32'd0);
    end
  endtask

  task automatic drive(input logic r, input logic h, input logic vs,
                       input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    @(negedge pclk);
    chk_dut(1, if1.out_href, if1.out_vsync, if1.out_y, if1.out_c, if1.out_c_sel);
    chk_dut(0, if0.out_href, if0.out_vsync, if0.out_y, if0.out_c, if0.out_c_sel);
    rst = r;
    if1.in_href = h; if1.in_vsync = vs; if1.in_y = y; if1.in_u = u; if1.in_v = v;
    if0.in_href = h; if0.in_vsync = vs; if0.in_y = y; if0.in_u = u; if0.in_v = v;
    exp_b_h = exp_a_h;
    exp_b_v = exp_a_v;
    exp_a_h = r ? 1'b0 : h;
    exp_a_v = r ? 1'b0 : vs;
    if (r) begin
      exp_b_h = 1'b0;
      exp_b_v = 1'b0;
    end
  endtask

  task automatic idle(input int k, input logic vs);
    for (int i = 0; i < k; i++) drive(1'b0, 1'b0, vs, 8'hEE, 8'hDD, 8'hCC);
  endtask

  task automatic drive_line(input int n, input logic vs);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, vs, ly[i], lu[i], lv[i]);
  endtask

  task automatic push(input int id, input logic [7:0] y, input logic [7:0] c, input logic sel);
    pix_t e;
    e.y = y; e.c = c; e.sel = sel;
    if (id == 1) q1.push_back(e); else q0.push_back(e);
  endtask

  // Reference: pixels 2k/2k+1 form a pair; a trailing even pixel keeps its own U.
  task automatic push_model(input int id, input int n);
    logic [7:0] c;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) begin
        if (i + 1 < n) c = (id == 1) ? avg(lu[i], lu[i+1]) : lu[i];
        else           c = lu[i];
        push(id, ly[i], c, 1'b0);
      end else begin
        c = (id == 1) ? avg(lv[i-1], lv[i]) : lv[i];
        push(id, ly[i], c, 1'b1);
      end
    end
  endtask

  initial begin
    // 1: reset for 3 cycles while a line is active
    rst = 1'b1;
    if1.in_href = 1'b1; if1.in_vsync = 1'b1; if1.in_y = 8'd9; if1.in_u = 8'd9; if1.in_v = 8'd9;
    if0.in_href = 1'b1; if0.in_vsync = 1'b1; if0.in_y = 8'd9; if0.in_u = 8'd9; if0.in_v = 8'd9;
    drive(1'b1, 1'b1, 1'b1, 8'd7, 8'd7, 8'd7);
    drive(1'b1, 1'b1, 1'b0, 8'd8, 8'd8, 8'd8);

    // 2/3: 4-px line, literal expectations for both variants
    ly[0] = 8'd10;  ly[1] = 8'd20;  ly[2] = 8'd30;  ly[3] = 8'd40;
    lu[0] = 8'd100; lu[1] = 8'd101; lu[2] = 8'd200; lu[3] = 8'd255;
    lv[0] = 8'd50;  lv[1] = 8'd53;  lv[2] = 8'd0;   lv[3] = 8'd255;
    push(1, 8'd10, 8'd101, 1'b0); push(1, 8'd20, 8'd52, 1'b1);
    push(1, 8'd30, 8'd228, 1'b0); push(1, 8'd40, 8'd128, 1'b1);
    push(0, 8'd10, 8'd100, 1'b0); push(0, 8'd20, 8'd53, 1'b1);
    push(0, 8'd30, 8'd200, 1'b0); push(0, 8'd40, 8'd255, 1'b1);
    drive_line(4, 1'b0);
    idle(3, 1'b0);

    // 4: 3-px line, last pixel unpaired
    ly[0] = 8'd1;  ly[1] = 8'd2;  ly[2] = 8'd3;
    lu[0] = 8'd10; lu[1] = 8'd20; lu[2] = 8'd30;
    lv[0] = 8'd40; lv[1] = 8'd50; lv[2] = 8'd60;
    push(1, 8'd1, 8'd15, 1'b0); push(1, 8'd2, 8'd45, 1'b1); push(1, 8'd3, 8'd30, 1'b0);
    push_model(0, 3);
    drive_line(3, 1'b0);
    idle(1, 1'b0);

    // 5: saturation, 8-px line of full-scale chroma
    for (int i = 0; i < 8; i++) begin
      ly[i] = 8'(50 + i); lu[i] = 8'd255; lv[i] = 8'd255;
      push(1, ly[i], 8'd255, 1'(i % 2));
      push(0, ly[i], 8'd255, 1'(i % 2));
    end
    drive_line(8, 1'b0);
    idle(2, 1'b0);

    // 6: vsync frame start, 5 px, single-cycle href gap, 4 px
    idle(2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      ly[i] = 8'(120 + i); lu[i] = 8'($urandom_range(0, 255)); lv[i] = 8'($urandom_range(0, 255));
    end
    push_model(1, 5); push_model(0, 5);
    drive_line(5, 1'b1);
    idle(1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ly[i] = 8'(200 + i); lu[i] = 8'($urandom_range(0, 255)); lv[i] = 8'($urandom_range(0, 255));
    end
    push_model(1, 4); push_model(0, 4);
    drive_line(4, 1'b0);
    idle(2, 1'b1);
    idle(4, 1'b0);

    expect_eq("avg_queue_drained", q1.size(), 32'd0);
    expect_eq("dec_queue_drained", q0.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
